tcp_rx_tmp_buf_slab_alloc: RTL and testbench

- Parametrised slab allocator for the TCP RX temporary payload buffer. Hands out and reclaims fixed-size slab indices via a hardware free list.
- Sits between the RX header/payload parser, which allocates a slab per incoming segment, and the store-buffer drain logic, which frees the slab once the payload is committed.
- Generalises the previously fixed 16 x 2048 B layout to any power-of-two slab count and size, adding double-free detection and a low-watermark flag.

---
 rtl/tcp_rx_tmp_buf_slab_alloc_pkg.sv | 35 +++
 rtl/tcp_rx_tmp_buf_slab_alloc_if.sv | 49 ++++
 rtl/tcp_slab_free_fifo.sv | 75 +++++++
 rtl/tcp_rx_tmp_buf_slab_alloc.sv | 145 ++++++++++++++
 tb/tb_tcp_rx_tmp_buf_slab_alloc.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tcp_rx_tmp_buf_slab_alloc_pkg.sv
// ----------------------------------------------------------------------------
// tcp_rx_tmp_buf_slab_alloc_pkg
// Shared constants and types for the TCP RX temporary payload buffer slab
// allocator. The RX_TMP_BUF_* constants give the default geometry
// (16 slabs x 2048 B, 64 B MAC lines). slab_alloc_resp_struct bundles one
// allocation result so parser pipelines can carry it as a single field.
// The FSM state constants are shared by the allocator and anything that
// wants to decode its state.
// ----------------------------------------------------------------------------
package tcp_rx_tmp_buf_slab_alloc_pkg;

  localparam int RX_TMP_BUF_NUM_SLABS  = 16;
  localparam int RX_TMP_BUF_SLAB_BYTES = 2048;
  localparam int RX_TMP_BUF_MAC_BYTES  = 64;
  localparam int RX_TMP_BUF_LOW_WATER  = 2;

  localparam int RX_TMP_BUF_SLAB_W       = $clog2(RX_TMP_BUF_NUM_SLABS);
  localparam int RX_TMP_BUF_SLAB_BYTES_W = $clog2(RX_TMP_BUF_SLAB_BYTES);
  localparam int RX_TMP_BUF_ADDR_W       = RX_TMP_BUF_SLAB_W + RX_TMP_BUF_SLAB_BYTES_W;
  localparam int RX_TMP_BUF_LINE_ADDR_W  =
    $clog2(RX_TMP_BUF_NUM_SLABS * RX_TMP_BUF_SLAB_BYTES / RX_TMP_BUF_MAC_BYTES);
  localparam int RX_TMP_BUF_CNT_W        = RX_TMP_BUF_SLAB_W + 1;

  // Allocator FSM states.
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // One allocation result at the default geometry.
  typedef struct packed {
    logic [RX_TMP_BUF_SLAB_W-1:0]      slab;
    logic [RX_TMP_BUF_ADDR_W-1:0]      byte_addr;
    logic [RX_TMP_BUF_LINE_ADDR_W-1:0] line_addr;
  } slab_alloc_resp_struct;

endpackage

// File: rtl/tcp_rx_tmp_buf_slab_alloc_if.sv
// ----------------------------------------------------------------------------
// tcp_rx_tmp_buf_slab_alloc_if
// Bundles the allocate/free handshakes and status outputs of the slab
// allocator.
//   slave  : the allocator (offers slabs, accepts frees, reports status)
//   master : the consumer side (parser takes slabs, drain logic frees them)
// Signals:
//   alloc_val/alloc_rdy/alloc_slab/alloc_byte_addr/alloc_line_addr
//   free_val/free_slab/free_rdy
//   free_cnt, almost_empty, init_done, err_double_free, err_pulse
// ----------------------------------------------------------------------------
interface tcp_rx_tmp_buf_slab_alloc_if
  import tcp_rx_tmp_buf_slab_alloc_pkg::*;
#(
  parameter int SLAB_W      = RX_TMP_BUF_SLAB_W,
  parameter int ADDR_W      = RX_TMP_BUF_ADDR_W,
  parameter int LINE_ADDR_W = RX_TMP_BUF_LINE_ADDR_W,
  parameter int CNT_W       = RX_TMP_BUF_CNT_W
);

  logic                   alloc_val;
  logic                   alloc_rdy;
  logic [SLAB_W-1:0]      alloc_slab;
  logic [ADDR_W-1:0]      alloc_byte_addr;
  logic [LINE_ADDR_W-1:0] alloc_line_addr;
  logic                   free_val;
  logic [SLAB_W-1:0]      free_slab;
  logic                   free_rdy;
  logic [CNT_W-1:0]       free_cnt;
  logic                   almost_empty;
  logic                   init_done;
  logic                   err_double_free;
  logic                   err_pulse;

  modport slave (
    output alloc_val, alloc_slab, alloc_byte_addr, alloc_line_addr,
    output free_rdy, free_cnt, almost_empty, init_done,
    output err_double_free, err_pulse,
    input  alloc_rdy, free_val, free_slab
  );

  modport master (
    input  alloc_val, alloc_slab, alloc_byte_addr, alloc_line_addr,
    input  free_rdy, free_cnt, almost_empty, init_done,
    input  err_double_free, err_pulse,
    output alloc_rdy, free_val, free_slab
  );

endinterface

// File: rtl/tcp_slab_free_fifo.sv
// ----------------------------------------------------------------------------
// tcp_slab_free_fifo
// Circular FIFO holding free slab indices. DEPTH entries of W bits with
// head/tail pointers and an occupancy count. The single write port is
// shared by the initial fill and by slab frees; the owner guarantees that
// it never writes when full or reads when empty.
// Ports:
//   clk, rst         clock, async active-high reset (pointers/count only)
//   wr_en, wr_data   push one index at tail
//   rd_en            pop the index at head
//   head_data        index currently at head (valid when count != 0)
//   count            registered occupancy
//   count_next       occupancy after this cycle's push/pop
// ----------------------------------------------------------------------------
module tcp_slab_free_fifo
  import tcp_rx_tmp_buf_slab_alloc_pkg::*;
#(
  parameter int DEPTH = RX_TMP_BUF_NUM_SLABS,
  parameter int W     = RX_TMP_BUF_SLAB_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rd_en) head_d = head_q + 1'b1;
    if (wr_en) tail_d = tail_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset: every entry is rewritten by the fill after reset
  // before it can be read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[tail_q] <= wr_data;
  end

  assign head_data  = mem_q[head_q];
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/tcp_rx_tmp_buf_slab_alloc.sv
// ----------------------------------------------------------------------------
// tcp_rx_tmp_buf_slab_alloc
// Slab allocator for the TCP RX temporary payload buffer. After reset it
// fills a free-list FIFO with slabs 0..NUM_SLABS-1 (one per cycle), then
// offers the head slab to the parser and takes slabs back from the drain
// logic. An in_use bitmap rejects frees of slabs that are not allocated.
// Ports:
//   clk, rst  clock, async active-high reset
//   bus       slave side of tcp_rx_tmp_buf_slab_alloc_if:
//             alloc_val/alloc_rdy/alloc_slab/alloc_byte_addr/alloc_line_addr,
//             free_val/free_slab/free_rdy, free_cnt, almost_empty,
//             init_done, err_double_free, err_pulse
// ----------------------------------------------------------------------------
module tcp_rx_tmp_buf_slab_alloc
  import tcp_rx_tmp_buf_slab_alloc_pkg::*;
#(
  parameter int NUM_SLABS  = RX_TMP_BUF_NUM_SLABS,
  parameter int SLAB_BYTES = RX_TMP_BUF_SLAB_BYTES,
  parameter int MAC_BYTES  = RX_TMP_BUF_MAC_BYTES,
  parameter int LOW_WATER  = RX_TMP_BUF_LOW_WATER
) (
  input logic                        clk,
  input logic                        rst,
  tcp_rx_tmp_buf_slab_alloc_if.slave bus
);

  localparam int SLAB_W       = $clog2(NUM_SLABS);
  localparam int SLAB_BYTES_W = $clog2(SLAB_BYTES);
  localparam int ADDR_W       = SLAB_W + SLAB_BYTES_W;
  localparam int MAC_W        = $clog2(MAC_BYTES);
  localparam int LINE_ADDR_W  = ADDR_W - MAC_W;
  localparam int CNT_W        = SLAB_W + 1;

  logic [0:0]           state_q, state_d;
  logic [SLAB_W-1:0]    fill_q, fill_d;
  logic [NUM_SLABS-1:0] in_use_q, in_use_d;
  logic                 err_sticky_q, err_sticky_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 almost_empty_q, almost_empty_d;

  logic                 fifo_wr_en;
  logic [SLAB_W-1:0]    fifo_wr_data;
  logic                 fifo_rd_en;
  logic [SLAB_W-1:0]    fifo_head;
  logic [CNT_W-1:0]     fifo_count;
  logic [CNT_W-1:0]     fifo_count_next;

  logic                 ready;
  logic                 alloc_val;
  logic                 alloc_fire;
  logic [SLAB_W-1:0]    alloc_slab;
  logic [ADDR_W-1:0]    byte_addr;

  tcp_slab_free_fifo #(
    .DEPTH (NUM_SLABS),
    .W     (SLAB_W)
  ) u_free_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (fifo_wr_en),
    .wr_data    (fifo_wr_data),
    .rd_en      (fifo_rd_en),
    .head_data  (fifo_head),
    .count      (fifo_count),
    .count_next (fifo_count_next)
  );

  // The offer depends only on registered state; the head slab is forced to
  // zero while nothing is offered so outputs stay clean through reset/INIT.
  always_comb begin
    ready      = (state_q == ST_READY);
    alloc_val  = ready && (fifo_count != '0);
    alloc_fire = alloc_val && bus.alloc_rdy;
    alloc_slab = alloc_val ? fifo_head : '0;
    byte_addr  = {alloc_slab, {SLAB_BYTES_W{1'b0}}};
  end

  // INIT pushes the fill pointer each cycle; READY arbitrates handshakes.
  // The in_use lookup uses pre-cycle state, so freeing the slab allocated in
  // the same cycle is rejected as a double free.
  always_comb begin
    state_d        = state_q;
    fill_d         = fill_q;
    in_use_d       = in_use_q;
    err_sticky_d   = err_sticky_q;
    err_pulse_d    = 1'b0;
    fifo_wr_en     = 1'b0;
    fifo_wr_data   = '0;
    fifo_rd_en     = 1'b0;

    if (!ready) begin
      fifo_wr_en   = 1'b1;
      fifo_wr_data = fill_q;
      fill_d       = fill_q + 1'b1;
      if (fill_q == SLAB_W'(NUM_SLABS - 1)) state_d = ST_READY;
    end else begin
      if (alloc_fire) begin
        fifo_rd_en           = 1'b1;
        in_use_d[alloc_slab] = 1'b1;
      end
      if (bus.free_val) begin
        if (in_use_q[bus.free_slab]) begin
          fifo_wr_en              = 1'b1;
          fifo_wr_data            = bus.free_slab;
          in_use_d[bus.free_slab] = 1'b0;
        end else begin
          err_pulse_d  = 1'b1;
          err_sticky_d = 1'b1;
        end
      end
    end

    almost_empty_d = (fifo_count_next <= CNT_W'(LOW_WATER));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_INIT;
      fill_q         <= '0;
      in_use_q       <= '0;
      err_sticky_q   <= 1'b0;
      err_pulse_q    <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      fill_q         <= fill_d;
      in_use_q       <= in_use_d;
      err_sticky_q   <= err_sticky_d;
      err_pulse_q    <= err_pulse_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign bus.alloc_val       = alloc_val;
  assign bus.alloc_slab      = alloc_slab;
  assign bus.alloc_byte_addr = byte_addr;
  assign bus.alloc_line_addr = byte_addr[ADDR_W-1:MAC_W];
  assign bus.free_rdy        = ready;
  assign bus.free_cnt        = fifo_count;
  assign bus.almost_empty    = almost_empty_q;
  assign bus.init_done       = ready;
  assign bus.err_double_free = err_sticky_q;
  assign bus.err_pulse       = err_pulse_q;

endmodule

// File: tb/tb_tcp_rx_tmp_buf_slab_alloc.sv
// ----------------------------------------------------------------------------
// tb_tcp_rx_tmp_buf_slab_alloc
// Drives the slab allocator through directed scenarios and a randomized
// alloc/free mix, comparing every output each cycle against a reference
// model built from a queue of free slabs and a per-slab allocated flag.
// ----------------------------------------------------------------------------
module tb_tcp_rx_tmp_buf_slab_alloc;

  localparam int NUM_SLABS   = 16;
  localparam int SLAB_BYTES  = 2048;
  localparam int MAC_BYTES   = 64;
  localparam int LOW_WATER   = 2;
  localparam int SLAB_W      = 4;
  localparam int ADDR_W      = 15;
  localparam int LINE_ADDR_W = 9;
  localparam int CNT_W       = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  tcp_rx_tmp_buf_slab_alloc_if #(
    .SLAB_W      (SLAB_W),
    .ADDR_W      (ADDR_W),
    .LINE_ADDR_W (LINE_ADDR_W),
    .CNT_W       (CNT_W)
  ) bus ();

  tcp_rx_tmp_buf_slab_alloc #(
    .NUM_SLABS  (NUM_SLABS),
    .SLAB_BYTES (SLAB_BYTES),
    .MAC_BYTES  (MAC_BYTES),
    .LOW_WATER  (LOW_WATER)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of free slabs in issue order, allocated flags,
  // init progress and error flags.
  int free_q[$];
  bit allocated_m [NUM_SLABS];
  bit ready_m;
  int init_idx;
  bit err_sticky_m;
  bit err_pulse_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    free_q.delete();
    foreach (allocated_m[i]) allocated_m[i] = 1'b0;
    ready_m      = 1'b0;
    init_idx     = 0;
    err_sticky_m = 1'b0;
    err_pulse_m  = 1'b0;
  endtask

  // Advances the model by one clock given this cycle's inputs.
  task automatic modelStep(input bit ar, input bit fv, input int fs);
    bit do_alloc;
    bit was_alloc;
    int a;
    if (!ready_m) begin
      free_q.push_back(init_idx);
      init_idx++;
      if (init_idx == NUM_SLABS) ready_m = 1'b1;
      err_pulse_m = 1'b0;
    end else begin
      was_alloc   = allocated_m[fs];
      do_alloc    = ar && (free_q.size() != 0);
      err_pulse_m = 1'b0;
      if (do_alloc) begin
        a = free_q.pop_front();
        allocated_m[a] = 1'b1;
      end
      if (fv) begin
        if (was_alloc) begin
          free_q.push_back(fs);
          allocated_m[fs] = 1'b0;
        end else begin
          err_pulse_m  = 1'b1;
          err_sticky_m = 1'b1;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input bit in_reset);
    bit exp_val;
    int s;
    exp_val = ready_m && (free_q.size() != 0);
    chk({tag, ".alloc_val"}, 32'(bus.alloc_val), 32'(exp_val));
    if (exp_val) begin
      s = free_q[0];
      chk({tag, ".alloc_slab"}, 32'(bus.alloc_slab), s);
      chk({tag, ".byte_addr"}, 32'(bus.alloc_byte_addr), s * SLAB_BYTES);
      chk({tag, ".line_addr"}, 32'(bus.alloc_line_addr), s * SLAB_BYTES / MAC_BYTES);
    end else if (in_reset) begin
      chk({tag, ".alloc_slab"}, 32'(bus.alloc_slab), 0);
      chk({tag, ".byte_addr"}, 32'(bus.alloc_byte_addr), 0);
      chk({tag, ".line_addr"}, 32'(bus.alloc_line_addr), 0);
    end
    chk({tag, ".free_rdy"}, 32'(bus.free_rdy), 32'(ready_m));
    chk({tag, ".free_cnt"}, 32'(bus.free_cnt), free_q.size());
    chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(free_q.size() <= LOW_WATER));
    chk({tag, ".init_done"}, 32'(bus.init_done), 32'(ready_m));
    chk({tag, ".err_double_free"}, 32'(bus.err_double_free), 32'(err_sticky_m));
    chk({tag, ".err_pulse"}, 32'(bus.err_pulse), 32'(err_pulse_m));
  endtask

  // Called at a falling edge: drive inputs, step the model, and check the
  // outputs at the next falling edge.
  task automatic applyStimulus(input bit ar, input bit fv, input int fs, input string tag);
    bus.alloc_rdy = ar;
    bus.free_val  = fv;
    bus.free_slab = SLAB_W'(fs);
    modelStep(ar, fv, fs);
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag, 1'b0);
  endtask

  // Asserts reset away from a clock edge, checks the cleared outputs right
  // away and again one edge later, then releases and runs the 16 init cycles.
  task automatic doReset(input string tag);
    bus.alloc_rdy = 1'b0;
    bus.free_val  = 1'b0;
    bus.free_slab = '0;
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput({tag, "_async"}, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_held"}, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < NUM_SLABS; i++) applyStimulus(1'b1, 1'b0, 0, {tag, "_init"});
  endtask

  function automatic int pickAllocated();
    int n;
    int k;
    n = 0;
    foreach (allocated_m[i]) if (allocated_m[i]) n++;
    if (n == 0) return -1;
    k = $urandom_range(0, n - 1);
    foreach (allocated_m[i]) begin
      if (allocated_m[i]) begin
        if (k == 0) return i;
        k--;
      end
    end
    return -1;
  endfunction

  initial begin
    int r;
    int p;
    bit ar;
    bit fv;
    int fs;

    bus.alloc_rdy = 1'b0;
    bus.free_val  = 1'b0;
    bus.free_slab = '0;
    modelReset();
    @(negedge clk);

    // Power-up init, then drain all 16 slabs in order and observe empty.
    doReset("por");
    for (int i = 0; i < NUM_SLABS; i++) applyStimulus(1'b1, 1'b0, 0, "drain");
    applyStimulus(1'b1, 1'b0, 0, "empty0");
    applyStimulus(1'b1, 1'b0, 0, "empty1");

    // Free into an empty list; the slab shows up on the next cycle.
    applyStimulus(1'b0, 1'b1, 5, "free5");
    applyStimulus(1'b0, 1'b0, 0, "free5_hold");

    // Free of a never-allocated slab after allocating 0..3.
    doReset("dfree");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 0, "alloc03");
    applyStimulus(1'b0, 1'b1, 9, "dfree9");
    applyStimulus(1'b0, 1'b0, 0, "dfree9_after");

    // Bring free count down to 3, then alloc + free of slab 1 together.
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 0, "to3");
    applyStimulus(1'b1, 1'b1, 1, "simul");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 0, "simul_drain");

    // FIFO order of returned slabs behind the remaining initial slabs.
    doReset("order");
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 0, "alloc7");
    applyStimulus(1'b0, 1'b1, 6, "free6");
    applyStimulus(1'b0, 1'b1, 2, "free2");
    applyStimulus(1'b0, 1'b1, 0, "free0");
    for (int i = 0; i < 13; i++) applyStimulus(1'b1, 1'b0, 0, "order_drain");

    // Randomized mix of allocs, legal frees, bogus frees and same-cycle
    // frees of the slab being allocated.
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      ar = 1'($urandom_range(0, 1));
      fv = 1'b0;
      fs = 0;
      if (r < 5) begin
        p = pickAllocated();
        if (p >= 0) begin
          fv = 1'b1;
          fs = p;
        end
      end else if (r == 5) begin
        fv = 1'b1;
        fs = $urandom_range(0, NUM_SLABS - 1);
      end else if (r == 6 && free_q.size() != 0) begin
        ar = 1'b1;
        fv = 1'b1;
        fs = free_q[0];
      end
      applyStimulus(ar, fv, fs, "rand");
    end

    // Reset in the middle of traffic with 10 slabs outstanding.
    doReset("mid");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 0, "alloc10");
    doReset("midrst");
    applyStimulus(1'b1, 1'b0, 0, "midrst_first");
    applyStimulus(1'b1, 1'b0, 0, "midrst_second");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
